// File: rtl/xor3_parity_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : xor3_seq_pkg
// Description : Shared types and helpers for the serial XOR3 parity sequencer.
//               - state_e : sequencer FSM encoding
//               - steps_f : number of RUN cycles needed to fold a word
// Revision    : 1.0 - initial release
// ============================================================================
package xor3_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Two bits are folded per RUN cycle; odd widths round up.
    function automatic int steps_f(input int width);
        return (width + 1) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xor3_parity_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface   : xor3_parity_sequencer_if
// Description : Producer-side and consumer-side valid/ready handshakes of the
//               parity sequencer.
//               IN_VALID/IN_READY/IN_DATA   : word from producer
//               OUT_VALID/OUT_READY/OUT_PARITY : parity to consumer
//               master : environment side (drives IN_*, OUT_READY)
//               slave  : sequencer side
// Revision    : 1.0 - initial release
// ============================================================================
interface xor3_parity_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] IN_DATA;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic             OUT_PARITY;

    modport master (
        output IN_VALID,
        input  IN_READY,
        output IN_DATA,
        input  OUT_VALID,
        output OUT_READY,
        input  OUT_PARITY
    );

    modport slave (
        input  IN_VALID,
        output IN_READY,
        input  IN_DATA,
        output OUT_VALID,
        input  OUT_READY,
        output OUT_PARITY
    );
endinterface
`default_nettype wire

// File: rtl/xor3_parity_sequencer_step.sv
`default_nettype none
// ============================================================================
// Module      : xor3_step
// Description : Single three-input XOR, Z = A1 ^ A2 ^ A3. Kept as its own
//               module so it maps onto one xor3 standard cell.
//               A1, A2, A3 : inputs
//               Z          : output
// Revision    : 1.0 - initial release
// ============================================================================
module xor3_step (
    input  wire logic A1,
    input  wire logic A2,
    input  wire logic A3,
    output logic      Z
);
    assign Z = A1 ^ A2 ^ A3;
endmodule
`default_nettype wire

// File: rtl/xor3_parity_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : xor3_parity_sequencer
// Description : Serial parity engine. Folds a WIDTH-bit word two bits per
//               clock through one shared XOR3 step (acc ^ bit0 ^ bit1).
//               Optional macro XOR3_PARITY_SEQUENCER_ODD_EN selects odd parity
//               (result inverted in DONE); default is even parity.
//               CLK  : clock, rising edge
//               RST  : asynchronous reset, active-high
//               bus  : producer/consumer handshakes (slave modport)
//               BUSY : high in RUN or DONE
// Revision    : 1.0 - initial release
// ============================================================================
module xor3_parity_sequencer
    import xor3_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire logic              CLK,
    input  wire logic              RST,
    xor3_parity_sequencer_if.slave bus,
    output logic                   BUSY
);
    localparam int STEPS = steps_f(WIDTH);
    localparam int PW    = 2 * STEPS;
    localparam int CNT_W = $clog2(STEPS) + 1;

`ifdef XOR3_PARITY_SEQUENCER_ODD_EN
    localparam logic c_ODD = 1'b1;
`else
    localparam logic c_ODD = 1'b0;
`endif

    state_e           state_q, state_d;
    logic             acc_q, acc_d;
    logic [PW-1:0]    shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_z;

    xor3_step u_step (
        .A1 (acc_q),
        .A2 (shreg_q[0]),
        .A3 (shreg_q[1]),
        .Z  (step_z)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            acc_q   <= 1'b0;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        shreg_d        = shreg_q;
        cnt_d          = cnt_q;
        bus.IN_READY   = 1'b0;
        bus.OUT_VALID  = 1'b0;
        bus.OUT_PARITY = 1'b0;
        BUSY           = 1'b0;

        case (state_q)
            IDLE: begin
                bus.IN_READY = 1'b1;
                if (bus.IN_VALID) begin
                    // Width cast zero-pads odd widths at the MSB.
                    shreg_d = PW'(bus.IN_DATA);
                    acc_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                BUSY    = 1'b1;
                acc_d   = step_z;
                shreg_d = shreg_q >> 2;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                BUSY           = 1'b1;
                bus.OUT_VALID  = 1'b1;
                bus.OUT_PARITY = acc_q ^ c_ODD;
                if (bus.OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_xor3_parity_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_xor3_parity_sequencer
// Description : Self-checking bench for xor3_parity_sequencer. Drives a
//               WIDTH=16 and a WIDTH=5 instance; expected parities are
//               hand-computed and inverted when XOR3_PARITY_SEQUENCER_ODD_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xor3_parity_sequencer;

`ifdef XOR3_PARITY_SEQUENCER_ODD_EN
    localparam logic c_ODD = 1'b1;
`else
    localparam logic c_ODD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        tb_sel;        // 0: WIDTH=16 instance, 1: WIDTH=5 instance
    logic        tb_valid;
    logic [15:0] tb_data;
    logic        tb_out_ready;
    logic        busy16, busy5;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    xor3_parity_sequencer_if #(.WIDTH(16)) b16 ();
    xor3_parity_sequencer_if #(.WIDTH(5))  b5  ();

    assign b16.IN_VALID  = tb_valid && !tb_sel;
    assign b16.IN_DATA   = tb_data;
    assign b16.OUT_READY = tb_out_ready;
    assign b5.IN_VALID   = tb_valid && tb_sel;
    assign b5.IN_DATA    = tb_data[4:0];
    assign b5.OUT_READY  = tb_out_ready;

    xor3_parity_sequencer #(.WIDTH(16)) dut16 (
        .CLK  (clk),
        .RST  (rst),
        .bus  (b16.slave),
        .BUSY (busy16)
    );

    xor3_parity_sequencer #(.WIDTH(5)) dut5 (
        .CLK  (clk),
        .RST  (rst),
        .bus  (b5.slave),
        .BUSY (busy5)
    );

    logic w_in_ready, w_out_valid, w_out_parity, w_busy;
    assign w_in_ready   = tb_sel ? b5.IN_READY   : b16.IN_READY;
    assign w_out_valid  = tb_sel ? b5.OUT_VALID  : b16.OUT_VALID;
    assign w_out_parity = tb_sel ? b5.OUT_PARITY : b16.OUT_PARITY;
    assign w_busy       = tb_sel ? busy5         : busy16;

    typedef struct {
        logic [15:0] data;
        logic        exp_par;   // even parity of data
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Wait for IN_READY, present one word, and check handshake, latency,
    // parity and the return to IDLE with OUT_READY held high.
    task automatic run_word(input logic sel, input logic [15:0] data,
                            input logic exp_par, input int steps, input string tag);
        int g;
        int lat;
        tb_sel       = sel;
        tb_out_ready = 1'b1;
        g = 0;
        while (w_in_ready !== 1'b1 && g < 30) begin
            @(negedge clk);
            g++;
        end
        check({tag, " in_ready before accept"}, 32'(w_in_ready), 32'd1);
        tb_valid = 1'b1;
        tb_data  = data;
        @(posedge clk);
        @(negedge clk);
        tb_valid = 1'b0;
        check({tag, " in_ready low after accept"}, 32'(w_in_ready), 32'd0);
        lat = 0;
        while (w_out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(steps));
        check({tag, " parity"}, 32'(w_out_parity), 32'(exp_par ^ c_ODD));
        @(negedge clk);
        check({tag, " idle in_ready"}, 32'(w_in_ready), 32'd1);
        check({tag, " idle out_valid"}, 32'(w_out_valid), 32'd0);
    endtask

    vec_t v16[8];
    vec_t v5[4];

    initial begin
        int lat;

        v16[0] = '{16'h0001, 1'b1};
        v16[1] = '{16'hFFFF, 1'b0};
        v16[2] = '{16'h0000, 1'b0};
        v16[3] = '{16'hA5A4, 1'b1};
        v16[4] = '{16'h8000, 1'b1};
        v16[5] = '{16'h1234, 1'b1};
        v16[6] = '{16'h0003, 1'b0};
        v16[7] = '{16'h00FF, 1'b0};
        v5[0]  = '{16'h0015, 1'b1};   // 5'b10101
        v5[1]  = '{16'h0011, 1'b0};   // 5'b10001
        v5[2]  = '{16'h001F, 1'b1};
        v5[3]  = '{16'h0000, 1'b0};

        tb_sel       = 1'b0;
        tb_valid     = 1'b0;
        tb_data      = '0;
        tb_out_ready = 1'b1;
        rst          = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst in_ready16",   32'(b16.IN_READY),   32'd1);
        check("rst out_valid16",  32'(b16.OUT_VALID),  32'd0);
        check("rst parity16",     32'(b16.OUT_PARITY), 32'd0);
        check("rst busy16",       32'(busy16),         32'd0);
        check("rst in_ready5",    32'(b5.IN_READY),    32'd1);
        check("rst out_valid5",   32'(b5.OUT_VALID),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven words, WIDTH=16 then WIDTH=5
        for (int i = 0; i < 8; i++) begin
            run_word(1'b0, v16[i].data, v16[i].exp_par, 8, $sformatf("w16[%0d]", i));
        end
        for (int i = 0; i < 4; i++) begin
            run_word(1'b1, v5[i].data, v5[i].exp_par, 3, $sformatf("w5[%0d]", i));
        end

        // Backpressure: result held while OUT_READY low, stray IN_VALID ignored
        tb_sel       = 1'b0;
        tb_out_ready = 1'b0;
        @(negedge clk);
        tb_valid = 1'b1;
        tb_data  = 16'h0007;
        @(posedge clk);
        @(negedge clk);
        tb_valid = 1'b0;
        lat = 0;
        while (w_out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("bp latency", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            tb_valid = 1'b1;
            tb_data  = 16'h0001;
            @(negedge clk);
            check($sformatf("bp out_valid[%0d]", i), 32'(w_out_valid),  32'd1);
            check($sformatf("bp parity[%0d]", i),    32'(w_out_parity), 32'(1'b1 ^ c_ODD));
            check($sformatf("bp busy[%0d]", i),      32'(w_busy),       32'd1);
            check($sformatf("bp in_ready[%0d]", i),  32'(w_in_ready),   32'd0);
        end
        tb_valid     = 1'b0;
        tb_out_ready = 1'b1;
        @(negedge clk);
        check("bp release out_valid", 32'(w_out_valid), 32'd0);
        check("bp release in_ready",  32'(w_in_ready),  32'd1);
        @(negedge clk);
        check("bp stray not captured", 32'(w_busy), 32'd0);

        // Reset asserted mid-RUN takes effect without a clock edge
        tb_valid = 1'b1;
        tb_data  = 16'h00FF;
        @(posedge clk);
        @(negedge clk);
        tb_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid busy before rst", 32'(w_busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid rst in_ready",  32'(w_in_ready),   32'd1);
        check("mid rst out_valid", 32'(w_out_valid),  32'd0);
        check("mid rst busy",      32'(w_busy),       32'd0);
        check("mid rst parity",    32'(w_out_parity), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_word(1'b0, 16'h0001, 1'b1, 8, "after rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, n_cmp=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
